// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-Lite master bridging a simple request/response client.
// Optional response timeout with drain is compiled in by AXIL_MASTER_TIMEOUT_EN.
module axil_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WR_B  = 3'd2,
    RD_AR = 3'd3,
    RD_R  = 3'd4,
    DONE  = 3'd5
`ifdef AXIL_MASTER_TIMEOUT_EN
    ,
    DRAIN = 3'd6
`endif
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_unused_resp;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0]        r_tmo_cnt;
  logic                    r_tmo;
  logic                    w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  logic                    w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT == 0);
`endif

  // Only resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign w_unused_resp = bresp[0] ^ rresp[0];

  assign w_aw_hs   = awvalid & awready;
  assign w_w_hs    = wvalid & wready;
  assign awaddr    = r_addr;
  assign araddr    = r_addr;
  assign awprot    = 3'b000;
  assign arprot    = 3'b000;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = (r_state == DONE) & r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = req_we ? WR : RD_AR;
        end
      end
      WR: begin
        // Each valid is a pure function of its own done flag, never of ready.
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        if ((r_aw_done | awready) && (r_w_done | wready)) begin
          w_next = WR_B;
        end
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          w_next = DONE;
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_next = DONE;
        end
`endif
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_next = RD_R;
        end
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          w_next = DONE;
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_next = DONE;
        end
`endif
      end
      DONE: begin
        rsp_valid = 1'b1;
        w_next    = IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
        if (r_tmo) begin
          w_next = DRAIN;
        end
`endif
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      DRAIN: begin
        // Swallow the late response so it cannot be mistaken for the next one.
        bready = 1'b1;
        rready = 1'b1;
        if (bvalid | rvalid) begin
          w_next = IDLE;
        end
      end
`endif
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_wstrb   <= req_wstrb;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
`endif
          end
        end
        WR: begin
          if (w_aw_hs) begin
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_done <= 1'b1;
          end
        end
        WR_B: begin
          if (bvalid) begin
            r_err <= bresp[1];
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_err <= 1'b1;
            r_tmo <= 1'b1;
          end
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
        end
        RD_R: begin
          if (rvalid) begin
            r_rdata <= rdata;
            r_err   <= rresp[1];
          end
`ifdef AXIL_MASTER_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_err <= 1'b1;
            r_tmo <= 1'b1;
          end
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// tb/tb_axil_master.sv - directed self-checking bench for axil_master with a reactive AXI4-Lite slave.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid = 1'b0;
  logic        rready;

  axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave knobs: a ready/valid fires once its trigger has been high for more than *_wait cycles.
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit          b_hold = 0;
  logic [1:0]  s_resp = 2'b00;
  logic [31:0] s_rdata = '0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  assign bresp = s_resp;
  assign rresp = s_resp;
  assign rdata = s_rdata;

  int          acc_q[$];
  int          rsp_q[$];
  logic        err_q[$];
  logic [31:0] rd_q[$];
  int          aw_cyc = -1, w_cyc = -1, ar_cyc = -1, b_start = -1;
  int          aw_hi = 0, w_hi = 0, viol = 0;
  logic [31:0] aw_addr_s = '0, w_data_s = '0, ar_addr_s = '0, prev_wdata = '0;
  logic [3:0]  w_strb_s = '0;
  logic        prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;
  logic        prev_arv = 0, prev_arr = 0, prev_br = 0;

  // Slave response and monitor share one block so handshake sampling sees settled readies.
  always @(negedge clk) begin
    aw_cnt  = awvalid ? aw_cnt + 1 : 0;
    w_cnt   = wvalid  ? w_cnt + 1  : 0;
    ar_cnt  = arvalid ? ar_cnt + 1 : 0;
    b_cnt   = bready  ? b_cnt + 1  : 0;
    r_cnt   = rready  ? r_cnt + 1  : 0;
    awready = awvalid && (aw_cnt > aw_wait);
    wready  = wvalid && (w_cnt > w_wait);
    arready = arvalid && (ar_cnt > ar_wait);
    bvalid  = bready && !b_hold && (b_cnt > b_wait);
    rvalid  = rready && (r_cnt > r_wait);
    if (rst) begin
      prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
      prev_arv = 0; prev_arr = 0; prev_br = 0;
    end else begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (rsp_valid) begin
        rsp_q.push_back(cyc);
        err_q.push_back(rsp_err);
        rd_q.push_back(rsp_rdata);
      end
      if (awvalid && awready) begin aw_cyc = cyc; aw_addr_s = awaddr; end
      if (wvalid && wready) begin w_cyc = cyc; w_data_s = wdata; w_strb_s = wstrb; end
      if (arvalid && arready) begin ar_cyc = cyc; ar_addr_s = araddr; end
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (bready && !prev_br) b_start = cyc;
      if (prev_awv && !prev_awr && !awvalid) viol++;
      if (prev_wv && !prev_wr && !wvalid) viol++;
      if (prev_arv && !prev_arr && !arvalid) viol++;
      if (prev_wv && !prev_wr && wdata !== prev_wdata) viol++;
      if (awprot !== 3'b000 || arprot !== 3'b000) viol++;
      prev_awv = awvalid; prev_awr = awready; prev_wv = wvalid; prev_wr = wready;
      prev_arv = arvalid; prev_arr = arready; prev_br = bready; prev_wdata = wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    acc_q.delete(); rsp_q.delete(); err_q.delete(); rd_q.delete();
    aw_cyc = -1; w_cyc = -1; ar_cyc = -1; aw_hi = 0; w_hi = 0;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n0;
    int n;
    n0 = acc_q.size();
    n  = 0;
    @(posedge clk); #1;
    req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
    while (acc_q.size() == n0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    if (acc_q.size() == n0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n_exp);
    int n;
    n = 0;
    while (rsp_q.size() < n_exp && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_count", rsp_q.size(), n_exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] srdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 32'h4,  32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        32'h0,        1'b0, 3};
    vt[1] = '{1'b0, 32'h8,  32'h0,        4'h0, 2'b00, 32'h12345678, 32'h12345678, 1'b0, 3};
    vt[2] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b10, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1, 3};
    vt[3] = '{1'b1, 32'h20, 32'h01020304, 4'h5, 2'b11, 32'h99999999, 32'h0,        1'b1, 3};
    vt[4] = '{1'b1, 32'h24, 32'hFFFF0000, 4'hC, 2'b01, 32'h0,        32'h0,        1'b0, 3};
    vt[5] = '{1'b0, 32'hFC, 32'h0,        4'h0, 2'b01, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", req_ready, 1);

    for (int i = 0; i < 6; i++) begin
      s_resp = vt[i].resp;
      s_rdata = vt[i].srdata;
      clr();
      issue(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb);
      wait_rsp(1);
      chk($sformatf("v%0d_ready_after_rsp", i), req_ready, 1);
      if (rsp_q.size() > 0 && acc_q.size() > 0) begin
        chk($sformatf("v%0d_latency", i), rsp_q[0] - acc_q[0], vt[i].exp_lat);
        chk($sformatf("v%0d_err", i), err_q[0], vt[i].exp_err);
        chk($sformatf("v%0d_rdata", i), rd_q[0], vt[i].exp_rdata);
        if (vt[i].we) begin
          chk($sformatf("v%0d_aw_cycle", i), aw_cyc - acc_q[0], 1);
          chk($sformatf("v%0d_w_cycle", i), w_cyc - acc_q[0], 1);
          chk($sformatf("v%0d_awaddr", i), aw_addr_s, vt[i].addr);
          chk($sformatf("v%0d_wdata", i), {w_strb_s, w_data_s}, {vt[i].strb, vt[i].wdata});
        end else begin
          chk($sformatf("v%0d_ar_cycle", i), ar_cyc - acc_q[0], 1);
          chk($sformatf("v%0d_araddr", i), ar_addr_s, vt[i].addr);
        end
      end
    end

    // Write data accepted 4 cycles after the address.
    w_wait = 4;
    s_resp = 2'b00;
    clr();
    issue(1'b1, 32'h40, 32'hCAFEF00D, 4'h3);
    wait_rsp(1);
    if (rsp_q.size() > 0 && acc_q.size() > 0) begin
      chk("slow_w_aw_cycle", aw_cyc - acc_q[0], 1);
      chk("slow_w_w_cycle", w_cyc - acc_q[0], 5);
      chk("slow_w_latency", rsp_q[0] - acc_q[0], 7);
    end
    chk("slow_w_aw_high_cycles", aw_hi, 1);
    chk("slow_w_w_high_cycles", w_hi, 5);
    chk("slow_w_wdata", w_data_s, 32'hCAFEF00D);
    repeat (5) @(posedge clk);
    #1;
    chk("slow_w_single_rsp", rsp_q.size(), 1);
    w_wait = 0;

    // Back-to-back reads with req_valid held high.
    s_resp = 2'b10;
    s_rdata = 32'h55AA55AA;
    clr();
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 32'h30; req_valid = 1'b1;
    for (int n = 0; n < 30 && acc_q.size() < 2; n++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_rsp(2);
    if (acc_q.size() == 2 && rsp_q.size() == 2) begin
      chk("b2b_second_accept", acc_q[1] - rsp_q[0], 1);
      chk("b2b_accept_gap", acc_q[1] - acc_q[0], 4);
      chk("b2b_err", {err_q[0], err_q[1]}, 2'b11);
      chk("b2b_rdata", rd_q[0], 32'h55AA55AA);
    end

    // Reset while waiting in WR_B.
    s_resp = 2'b00;
    b_hold = 1;
    clr();
    issue(1'b1, 32'h50, 32'h11112222, 4'hF);
    for (int n = 0; n < 10 && !bready; n++) begin
      @(posedge clk); #1;
    end
    chk("reached_wr_b", bready, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}, 0);
    chk("midreset_regs", {awaddr, wdata, rsp_rdata}, 0);
    rst = 1'b0;
    b_hold = 0;
    @(posedge clk); #1;
    chk("midreset_ready", req_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("midreset_no_rsp", rsp_q.size(), 0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    b_hold = 1;
    s_resp = 2'b00;
    clr();
    issue(1'b1, 32'h60, 32'h33334444, 4'hF);
    repeat (20) @(posedge clk);
    #1;
    chk("tmo_rsp_count", rsp_q.size(), 1);
    if (rsp_q.size() > 0) begin
      chk("tmo_cycle", rsp_q[0] - b_start, 8);
      chk("tmo_err", err_q[0], 1);
      chk("tmo_rdata", rd_q[0], 0);
    end
    chk("tmo_drain_ready", {req_ready, bready}, 2'b01);
    b_hold = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("tmo_idle_after_drain", req_ready, 1);
`else
    b_hold = 1;
    s_resp = 2'b10;
    clr();
    issue(1'b1, 32'h60, 32'h33334444, 4'hF);
    repeat (30) @(posedge clk);
    #1;
    chk("wait_forever_no_rsp", rsp_q.size(), 0);
    chk("wait_forever_bready", bready, 1);
    b_hold = 0;
    wait_rsp(1);
    if (err_q.size() > 0) chk("wait_forever_err", err_q[0], 1);
`endif

    chk("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite and request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, response timeout in cycles (used only under REQ-032).
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port req_valid  in  1  client request valid.
REQ-007 SHALL have port req_ready  out  1  module idle, request accepted this cycle.
REQ-008 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  in  ADDR_WIDTH  target address.
REQ-010 SHALL have port req_wdata  in  DATA_WIDTH  write data.
REQ-011 SHALL have port req_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port rsp_err  out  1  completion carried a non-OKAY response or timed out.
REQ-015 SHALL have ports awaddr out ADDR_WIDTH, awprot out 3, awvalid out 1, awready in 1: AXI4-Lite write address channel.
REQ-016 SHALL have ports wdata out DATA_WIDTH, wstrb out DATA_WIDTH/8, wvalid out 1, wready in 1: write data channel.
REQ-017 SHALL have ports bresp in 2, bvalid in 1, bready out 1: write response channel.
REQ-018 SHALL have ports araddr out ADDR_WIDTH, arprot out 3, arvalid out 1, arready in 1: read address channel.
REQ-019 SHALL have ports rdata in DATA_WIDTH, rresp in 2, rvalid in 1, rready out 1: read data channel.

Function
REQ-020 SHALL implement FSM states IDLE, WR, WR_B, RD_AR, RD_R, DONE (plus DRAIN under REQ-032); one transaction outstanding at a time.
REQ-021 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready, capture req_we/addr/wdata/wstrb and go to WR (we=1) or RD_AR (we=0).
REQ-022 SHALL, in WR, assert awvalid and wvalid from the first WR cycle, holding awaddr/wdata/wstrb stable; each valid drops the cycle after its own handshake, in either order or simultaneously; when both are done, go to WR_B.
REQ-023 SHALL, in WR_B, assert bready=1; on bvalid, record bresp and go to DONE.
REQ-024 SHALL, in RD_AR, assert arvalid until arready, then go to RD_R; in RD_R, assert rready=1; on rvalid, capture rdata/rresp and go to DONE.
REQ-025 SHALL never make any valid depend combinationally on the matching ready, and never withdraw a valid before its handshake.
REQ-026 SHALL, in DONE, pulse rsp_valid for exactly one cycle with rsp_err = resp[1] (SLVERR/DECERR), rsp_rdata = captured rdata for reads or 0 for writes, then return to IDLE.
REQ-027 SHALL drive awprot=arprot=3'b000 and awaddr/araddr = captured address.
REQ-028 SHALL hold bready=0 outside WR_B/DRAIN and rready=0 outside RD_R/DRAIN; bvalid/rvalid in other states are ignored.
REQ-029 SHALL, with an always-ready zero-wait slave, give latency accept->rsp_valid of 3 cycles for writes and 3 for reads; req_ready returns the cycle after rsp_valid.

Reset
REQ-030 SHALL, on rst, force state IDLE; awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err = 0; rsp_rdata and captured registers = 0; req_ready = 1 from the first cycle after rst deasserts; a transaction in flight is abandoned.

Configuration
REQ-031 SHALL compile the timeout feature only when macro AXIL_MASTER_TIMEOUT_EN is defined.
REQ-032 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, count cycles in WR_B/RD_R; on reaching TIMEOUT go to DONE with rsp_err=1, rsp_rdata=0, then DRAIN (bready/rready=1, req_ready=0) until the late bvalid/rvalid, then IDLE; without the macro, no counter exists and the FSM waits indefinitely.

Verification
REQ-033 SHALL cover write addr=0x4, wdata=0xDEADBEEF, wstrb=0xF, slave always ready, bresp=0 -> AW/W handshake cycle 1, rsp_valid cycle 3, rsp_err=0.
REQ-034 SHALL cover write with wready delayed 4 cycles after awready -> awvalid drops after AW handshake, wvalid held with stable data, single rsp_valid.
REQ-035 SHALL cover read addr=0x8, slave returns rdata=0x12345678, rresp=0 -> rsp_rdata=0x12345678, rsp_err=0.
REQ-036 SHALL cover read with rresp=2'b10 -> rsp_err=1; back-to-back req_valid held -> second request accepted only the cycle after rsp_valid.
REQ-037 SHALL cover rst asserted in WR_B, and (macro defined, TIMEOUT=8) bvalid withheld 20 cycles -> reset gives all valids 0 next cycle; timeout gives rsp_err=1 at cycle 8 of WR_B, req_ready=0 until bvalid.
